ping_pong_ctrl: RTL and testbench

PING_PONG_CTRL -- requirements
Module: ping_pong_ctrl

---
 rtl/ping_pong_ctrl.sv | 112 +++++++++++
 tb/tb_ping_pong_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer controller: streams upstream words into one bank of an external
// two-bank buffer while draining the other bank downstream, swapping when both sides allow.
module ping_pong_ctrl #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BIT_LENGTH-1:0]      s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BIT_LENGTH-1:0]      m_data,
  output logic                       m_last,
  output logic [$clog2(DEPTH)-1:0]   addra,
  output logic [$clog2(DEPTH)-1:0]   addrb,
  output logic [BIT_LENGTH-1:0]      dina,
  output logic                       ena,
  output logic                       wea,
  output logic                       enb,
  input  logic [BIT_LENGTH-1:0]      doutb,
  output logic                       ping_pong,
  output logic                       bank_swap
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0] wr_addr_r;
  logic [AW-1:0] rd_addr_r;
  logic          wr_full_r;
  logic          rd_busy_r;
  logic          ping_pong_r;
  logic          m_valid_r;
  logic          m_last_r;

  logic          wr_hs_s;
  logic          swap_s;
  logic          enb_s;

  // A full write bank blocks upstream; the swap cycle itself therefore never carries a write.
  assign s_ready   = ~wr_full_r;
  assign wr_hs_s   = s_valid & ~wr_full_r;
  assign swap_s    = wr_full_r & ~rd_busy_r;
  // Reads are issued only when the output register is empty or being drained this cycle.
  assign enb_s     = rd_busy_r & (~m_valid_r | m_ready);

  assign ena       = wr_hs_s;
  assign wea       = wr_hs_s;
  assign addra     = wr_addr_r;
  assign dina      = s_data;
  assign enb       = enb_s;
  assign addrb     = rd_addr_r;
  assign m_data    = doutb;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign ping_pong = ping_pong_r;
  assign bank_swap = swap_s;

  // Write-side address and bank-full tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r <= {AW{1'b0}};
      wr_full_r <= 1'b0;
    end else if (swap_s) begin
      wr_full_r <= 1'b0;
    end else if (wr_hs_s) begin
      if (wr_addr_r == LAST_ADDR) begin
        wr_addr_r <= {AW{1'b0}};
        wr_full_r <= 1'b1;
      end else begin
        wr_addr_r <= wr_addr_r + AW'(1);
      end
    end
  end

  // Read-side issue address, busy flag and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_r   <= {AW{1'b0}};
      rd_busy_r   <= 1'b0;
      ping_pong_r <= 1'b0;
    end else if (swap_s) begin
      rd_addr_r   <= {AW{1'b0}};
      rd_busy_r   <= 1'b1;
      ping_pong_r <= ~ping_pong_r;
    end else if (enb_s) begin
      if (rd_addr_r == LAST_ADDR) begin
        rd_addr_r <= {AW{1'b0}};
        rd_busy_r <= 1'b0;
      end else begin
        rd_addr_r <= rd_addr_r + AW'(1);
      end
    end
  end

  // Downstream valid/last follow the buffer's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (enb_s) begin
      m_valid_r <= 1'b1;
      m_last_r  <= (rd_addr_r == LAST_ADDR);
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Directed bench for ping_pong_ctrl (DEPTH=4, BIT_LENGTH=8) with a two-bank buffer model
// and an in-order scoreboard of accepted upstream words.
module tb_ping_pong_ctrl;

  logic       clk;
  logic       rst_n;
  logic       s_valid, s_ready, m_valid, m_ready, m_last;
  logic       ena, wea, enb, ping_pong, bank_swap;
  logic [7:0] s_data, m_data, dina, doutb;
  logic [1:0] addra, addrb;
  logic [7:0] mem [2][4];

  int         checks, errors, out_cnt, last_pos, swaps, stalls, odd_stalls;
  int         acc, target;
  logic [7:0] exp_q [$];

  ping_pong_ctrl #(.BIT_LENGTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .addra(addra), .addrb(addrb), .dina(dina),
    .ena(ena), .wea(wea), .enb(enb), .doutb(doutb),
    .ping_pong(ping_pong), .bank_swap(bank_swap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External buffer: write bank ~ping_pong, registered read from bank ping_pong.
  always @(posedge clk) begin
    if (ena && wea) mem[~ping_pong][addra] <= dina;
    if (enb) doutb <= mem[ping_pong][addrb];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [7:0] e;
    if (rst_n && s_valid && s_ready) exp_q.push_back(s_data);
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e));
        check("m_last", 32'(m_last), 32'(last_pos % 4 == 3));
        last_pos++;
        out_cnt++;
      end
    end
    if (bank_swap) swaps++;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #1;
    cyc();
  endtask

  task automatic drain(input int tgt);
    m_ready = 1'b1;
    for (int k = 0; k < 200 && out_cnt < tgt; k++) step();
    check("drain_cnt", 32'(out_cnt), 32'(tgt));
  endtask

  task automatic feed(input int n, input logic [7:0] base);
    s_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 60 && acc < n; k++) begin
      s_data = 8'(base + 8'(acc));
      #1;
      if (!s_ready) begin
        stalls++;
        if (!bank_swap) odd_stalls++;
      end else begin
        acc++;
      end
      cyc();
    end
    s_valid = 1'b0;
    check("feed_cnt", 32'(acc), 32'(n));
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_enb", 32'(enb), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_bank_swap", 32'(bank_swap), 32'd0);
    check("rst_ping_pong", 32'(ping_pong), 32'd0);
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_addrb", 32'(addrb), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; out_cnt = 0; last_pos = 0; swaps = 0;
    stalls = 0; odd_stalls = 0; acc = 0; target = 0;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic bank: writes in cycles 0-3, swap in 4, reads emerge from cycle 6.
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'h10 + 8'(i));
      #1;
      check("t1_ena", 32'(ena), 32'd1);
      check("t1_addra", 32'(addra), 32'(i));
      check("t1_dina", 32'(dina), 32'(8'h10 + 8'(i)));
      check("t1_ping_pong", 32'(ping_pong), 32'd0);
      cyc();
    end
    s_valid = 1'b0;
    #1;
    check("t1_swap", 32'(bank_swap), 32'd1);
    check("t1_s_ready_full", 32'(s_ready), 32'd0);
    cyc();
    #1;
    check("t1_pp_toggled", 32'(ping_pong), 32'd1);
    check("t1_swap_pulse", 32'(bank_swap), 32'd0);
    check("t1_enb", 32'(enb), 32'd1);
    check("t1_addrb", 32'(addrb), 32'd0);
    check("t1_m_valid_early", 32'(m_valid), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t1_m_valid", 32'(m_valid), 32'd1);
      check("t1_m_data", 32'(m_data), 32'(8'h10 + 8'(i)));
      check("t1_m_last", 32'(m_last), 32'(i == 3));
      cyc();
    end
    #1;
    check("t1_m_valid_end", 32'(m_valid), 32'd0);
    check("t1_enb_end", 32'(enb), 32'd0);
    cyc();

    // Continuous 12-word stream: only the swap cycles stall upstream.
    target = out_cnt + 12;
    acc = swaps;
    stalls = 0; odd_stalls = 0;
    begin
      int sw0;
      sw0 = acc;
      feed(12, 8'h50);
      check("t2_stalls", 32'(stalls), 32'd2);
      check("t2_stall_not_swap", 32'(odd_stalls), 32'd0);
      drain(target);
      check("t2_swaps", 32'(swaps - sw0), 32'd3);
      check("t2_ping_pong", 32'(ping_pong), 32'd0);
    end

    // Downstream stall for 5 cycles holds m_data and blocks reads.
    target = out_cnt + 4;
    m_ready = 1'b0;
    feed(4, 8'hA0);
    for (int k = 0; k < 10 && !m_valid; k++) step();
    check("t3_m_valid", 32'(m_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_enb_stall", 32'(enb), 32'd0);
      check("t3_valid_hold", 32'(m_valid), 32'd1);
      check("t3_data_hold", 32'(m_data), 32'h0000_00A0);
      cyc();
    end
    drain(target);
    check("t3_ping_pong", 32'(ping_pong), 32'd1);

    // Two banks filled with downstream blocked: upstream must stall.
    target = out_cnt + 8;
    m_ready = 1'b0;
    feed(8, 8'h20);
    s_valid = 1'b1;
    s_data = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_s_ready", 32'(s_ready), 32'd0);
      check("t4_ena", 32'(ena), 32'd0);
      cyc();
    end
    s_valid = 1'b0;
    drain(target);

    // Reset mid-bank discards the partial words.
    m_ready = 1'b1;
    feed(2, 8'h30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    last_pos = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    target = out_cnt + 4;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'h40 + 8'(i));
      #1;
      check("t5_ena", 32'(ena), 32'd1);
      check("t5_addra", 32'(addra), 32'(i));
      check("t5_ping_pong", 32'(ping_pong), 32'd0);
      cyc();
    end
    s_valid = 1'b0;
    drain(target);

    // Random handshakes over 1000 words.
    acc = 0;
    target = out_cnt + 1000;
    for (int k = 0; k < 20000 && acc < 1000; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      #1;
      if (s_valid && s_ready) acc++;
      cyc();
    end
    s_valid = 1'b0;
    check("t6_accepted", 32'(acc), 32'd1000);
    drain(target);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
